// File: rtl/epd.sv
// Ethernet packet detector: monitors a byte stream and flags preamble/SFD, DST, SRC, type/length and frame size.
// Optional COUNTER_SATURATE_EN makes valid_packet_counter saturate at 15 instead of wrapping.
module epd #(
    parameter logic [47:0] DST_ADDR  = 48'h010203040506,
    parameter logic [47:0] SRC_ADDR  = 48'hFFFEFDFCFBFA,
    parameter logic [15:0] TYPE_LEN  = 16'h0800,
    parameter int unsigned MIN_FRAME = 64,
    parameter int unsigned MAX_FRAME = 1518
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       control,
    output logic       preamble_valid,
    output logic       dst_addr_valid,
    output logic       src_addr_valid,
    output logic       type_length_valid,
    output logic       packet_size_valid,
    output logic [3:0] valid_packet_counter
);

    typedef enum logic [2:0] {PREAMBLE, DST, SRC, TYPE, PAYLOAD, DROP} state_t;

    state_t      state, state_next;
    logic [2:0]  pre_cnt;
    logic [2:0]  fidx;
    logic        match;
    logic [10:0] frame_len;
    logic        gap;

    logic [47:0] dst_sh, src_sh;
    logic [15:0] type_sh;
    logic [7:0]  exp_byte;
    logic        field_last;
    logic        byte_ok;
    logic        size_ok;
    logic        all_ok;
    logic        in_frame;

    always_comb begin
        dst_sh     = DST_ADDR << (8 * fidx);
        src_sh     = SRC_ADDR << (8 * fidx);
        type_sh    = TYPE_LEN << (8 * fidx);
        exp_byte   = '0;
        field_last = 1'b0;
        case (state)
            DST: begin
                exp_byte   = dst_sh[47:40];
                field_last = (fidx == 3'd5);
            end
            SRC: begin
                exp_byte   = src_sh[47:40];
                field_last = (fidx == 3'd5);
            end
            TYPE: begin
                exp_byte   = type_sh[15:8];
                field_last = (fidx == 3'd1);
            end
            default: ;
        endcase
        // match carries the running result of earlier bytes; byte 0 starts fresh
        byte_ok  = (data == exp_byte) && ((fidx == 3'd0) || match);
        size_ok  = (32'(frame_len) >= MIN_FRAME) && (32'(frame_len) <= MAX_FRAME);
        all_ok   = preamble_valid && dst_addr_valid && src_addr_valid
                   && type_length_valid && size_ok;
        in_frame = (state == DST) || (state == SRC) || (state == TYPE) || (state == PAYLOAD);
    end

    always_comb begin
        state_next = state;
        case (state)
            PREAMBLE: if (control && data == 8'hD5) state_next = (pre_cnt == 3'd7) ? DST : DROP;
            DST:      if (!control) state_next = PREAMBLE; else if (field_last) state_next = SRC;
            SRC:      if (!control) state_next = PREAMBLE; else if (field_last) state_next = TYPE;
            TYPE:     if (!control) state_next = PREAMBLE; else if (field_last) state_next = PAYLOAD;
            PAYLOAD:  if (!control) state_next = PREAMBLE;
            DROP:     if (!control) state_next = PREAMBLE;
            default:  state_next = PREAMBLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= PREAMBLE;
        else       state <= state_next;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pre_cnt              <= '0;
            fidx                 <= '0;
            match                <= 1'b0;
            frame_len            <= '0;
            gap                  <= 1'b0;
            preamble_valid       <= 1'b0;
            dst_addr_valid       <= 1'b0;
            src_addr_valid       <= 1'b0;
            type_length_valid    <= 1'b0;
            packet_size_valid    <= 1'b0;
            valid_packet_counter <= '0;
        end else begin
            gap <= !control;

            // Flags survive the IFG and drop on the first byte of the next packet
            if (control && gap) begin
                preamble_valid    <= 1'b0;
                dst_addr_valid    <= 1'b0;
                src_addr_valid    <= 1'b0;
                type_length_valid <= 1'b0;
                packet_size_valid <= 1'b0;
            end

            if (state == PREAMBLE && control && data == 8'h55) begin
                if (pre_cnt != 3'd7) pre_cnt <= pre_cnt + 3'd1;
            end else begin
                pre_cnt <= '0;
            end

            if (state == PREAMBLE && control && data == 8'hD5 && pre_cnt == 3'd7)
                preamble_valid <= 1'b1;

            if (control && (state == DST || state == SRC || state == TYPE)) begin
                fidx  <= field_last ? 3'd0 : fidx + 3'd1;
                match <= byte_ok;
                if (field_last) begin
                    if (state == DST) dst_addr_valid    <= byte_ok;
                    if (state == SRC) src_addr_valid    <= byte_ok;
                    if (state == TYPE) type_length_valid <= byte_ok;
                end
            end else begin
                fidx  <= '0;
                match <= 1'b0;
            end

            if (!in_frame) begin
                frame_len <= '0;
            end else if (control && frame_len != 11'h7FF) begin
                frame_len <= frame_len + 11'd1;
            end

            if (!control && in_frame) begin
                packet_size_valid <= (state == PAYLOAD) && size_ok;
                if (state == PAYLOAD && all_ok) begin
`ifdef COUNTER_SATURATE_EN
                    if (valid_packet_counter != 4'hF)
                        valid_packet_counter <= valid_packet_counter + 4'd1;
`else
                    valid_packet_counter <= valid_packet_counter + 4'd1;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_epd.sv
// Directed self-checking bench for epd: builds frames byte by byte and compares flags/counter to hand-derived values.
module tb_epd;

    localparam logic [47:0] DST = 48'h010203040506;
    localparam logic [47:0] SRC = 48'hFFFEFDFCFBFA;
    localparam logic [15:0] TL  = 16'h0800;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] data = '0;
    logic       control = 1'b0;
    logic       preamble_valid, dst_addr_valid, src_addr_valid;
    logic       type_length_valid, packet_size_valid;
    logic [3:0] valid_packet_counter;

    int unsigned n_checks = 0;
    int unsigned n_pass = 0;

    epd dut (
        .clock               (clock),
        .reset               (reset),
        .data                (data),
        .control             (control),
        .preamble_valid      (preamble_valid),
        .dst_addr_valid      (dst_addr_valid),
        .src_addr_valid      (src_addr_valid),
        .type_length_valid   (type_length_valid),
        .packet_size_valid   (packet_size_valid),
        .valid_packet_counter(valid_packet_counter)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic check_flags(input string tag, input bit p, input bit d, input bit s,
                               input bit t, input bit z, input int c);
        check({tag, ".pre"},  32'(preamble_valid),       32'(p));
        check({tag, ".dst"},  32'(dst_addr_valid),       32'(d));
        check({tag, ".src"},  32'(src_addr_valid),       32'(s));
        check({tag, ".type"}, 32'(type_length_valid),    32'(t));
        check({tag, ".size"}, 32'(packet_size_valid),    32'(z));
        check({tag, ".cnt"},  32'(valid_packet_counter), 32'(c));
    endtask

    task automatic send_byte(input logic [7:0] b);
        data    = b;
        control = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        data    = '0;
        control = 1'b0;
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic send_pre(input int n);
        for (int i = 0; i < n; i++) send_byte(8'h55);
        send_byte(8'hD5);
    endtask

    task automatic send_hdr(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t);
        for (int i = 5; i >= 0; i--) send_byte(d[8*i +: 8]);
        for (int i = 5; i >= 0; i--) send_byte(s[8*i +: 8]);
        for (int i = 1; i >= 0; i--) send_byte(t[8*i +: 8]);
    endtask

    // n bytes after the type field: n-1 payload bytes plus one FCS byte
    task automatic send_pay(input int n);
        for (int i = 0; i < n - 1; i++) send_byte(8'h55);
        send_byte(8'hA7);
    endtask

    task automatic send_frame(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t,
                              input int pre_n, input int pay_n);
        send_pre(pre_n);
        send_hdr(d, s, t);
        send_pay(pay_n);
    endtask

    initial begin
        #2 reset = 1'b1;
        #1 check_flags("reset", 0, 0, 0, 0, 0, 0);
        @(posedge clock);
        @(posedge clock);
        #1 reset = 1'b0;
        idle(1);

        // 64-byte frame with a leading junk byte
        send_byte(8'h00);
        send_pre(7);
        check_flags("sfd", 1, 0, 0, 0, 0, 0);
        send_hdr(DST, SRC, TL);
        check_flags("hdr", 1, 1, 1, 1, 0, 0);
        send_pay(50);
        idle(1);
        check_flags("f64", 1, 1, 1, 1, 1, 1);
        idle(2);
        check_flags("hold", 1, 1, 1, 1, 1, 1);

        // DST bytes 5-6 corrupted, 3-cycle IFG
        send_byte(8'h55);
        check_flags("clr", 0, 0, 0, 0, 0, 1);
        send_frame(48'h01020304FFFF, SRC, TL, 6, 50);
        idle(3);
        check_flags("baddst", 1, 0, 1, 1, 1, 1);

        // reset during IFG
        reset = 1'b1;
        #1 check_flags("rst_async", 0, 0, 0, 0, 0, 0);
        @(posedge clock);
        @(posedge clock);
        #1 reset = 1'b0;
        idle(1);
        send_frame(DST, 48'hFFFEFDFC0000, TL, 7, 50);
        idle(1);
        check_flags("badsrc", 1, 1, 0, 1, 1, 0);
        send_frame(DST, SRC, TL, 7, 50);
        idle(1);
        check_flags("valid2", 1, 1, 1, 1, 1, 1);

        // size boundaries; long preamble also exercises count saturation
        send_frame(DST, SRC, TL, 10, 30);
        idle(1);
        check_flags("f44", 1, 1, 1, 1, 0, 1);
        send_frame(DST, SRC, TL, 7, 49);
        idle(1);
        check_flags("f63", 1, 1, 1, 1, 0, 1);
        send_frame(DST, SRC, TL, 7, 1505);
        idle(1);
        check_flags("f1519", 1, 1, 1, 1, 0, 1);
        send_frame(DST, SRC, TL, 7, 1504);
        idle(1);
        check_flags("f1518", 1, 1, 1, 1, 1, 2);

        // short preamble goes to DROP; rest of frame ignored
        send_frame(DST, SRC, TL, 5, 50);
        idle(1);
        check_flags("shortpre", 0, 0, 0, 0, 0, 2);

        // truncated after 3 DST bytes
        send_pre(7);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        idle(1);
        check_flags("trunc", 1, 0, 0, 0, 0, 2);

        // interrupted preamble count then a valid frame
        for (int i = 0; i < 4; i++) send_byte(8'h55);
        send_byte(8'h00);
        send_frame(DST, SRC, TL, 7, 50);
        idle(1);
        check_flags("restart", 1, 1, 1, 1, 1, 3);

        // counter wrap / saturation
        reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        idle(1);
        for (int k = 0; k < 15; k++) begin
            send_frame(DST, SRC, TL, 7, 50);
            idle(1);
        end
        check("cnt15", 32'(valid_packet_counter), 32'd15);
        send_frame(DST, SRC, TL, 7, 50);
        idle(1);
`ifdef COUNTER_SATURATE_EN
        check("cnt16", 32'(valid_packet_counter), 32'd15);
`else
        check("cnt16", 32'(valid_packet_counter), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/epd.md
Name: epd

Overview:
- Ethernet packet detector. Parses a byte-wide MAC-side stream qualified by `control`.
- Checks preamble/SFD, destination MAC, source MAC, type/length and frame size.
- Exposes one validity flag per field and a 4-bit count of fully valid packets.
- Sits behind the byte interface of the receive path as a monitor only; it never modifies data.

Parameters:
- DST_ADDR, 48'h010203040506, expected destination MAC; first byte on the wire is the MSB.
- SRC_ADDR, 48'hFFFEFDFCFBFA, expected source MAC; first byte on the wire is the MSB.
- TYPE_LEN, 16'h0800, expected type/length field; first byte on the wire is the MSB.
- MIN_FRAME, 64, minimum legal frame length in bytes (DST through FCS inclusive).
- MAX_FRAME, 1518, maximum legal frame length in bytes.

Ports:
- clock  in  1  rising-edge clock; one byte sampled per edge
- reset  in  1  asynchronous, active-high reset
- data  in  8  stream byte
- control  in  1  1 = byte belongs to a packet; 0 = inter-frame gap (IFG)
- preamble_valid  out  1  seven or more 0x55 bytes followed by 0xD5 were received
- dst_addr_valid  out  1  6 DST bytes equal DST_ADDR
- src_addr_valid  out  1  6 SRC bytes equal SRC_ADDR
- type_length_valid  out  1  2 bytes equal TYPE_LEN
- packet_size_valid  out  1  frame length within [MIN_FRAME, MAX_FRAME]
- valid_packet_counter  out  4  number of packets with all five checks passing

Behaviour:
- Reset (async, active-high):
  - state = PREAMBLE; all flags = 0; valid_packet_counter = 0; internal counters = 0.
  - Reset asserted mid-packet abandons that packet; after release the block hunts for a new preamble.
- All logic is registered on the rising clock edge. Flags are registered outputs and update on the edge that samples the last byte of their field (1-cycle latency).
- States and transitions:
  - PREAMBLE:
    - Counts consecutive 0x55 bytes in a counter saturating at 7; any other non-0xD5 byte clears the count.
    - 0xD5 with count ≥ 7 sets preamble_valid = 1 and moves to DST.
    - 0xD5 with count < 7 moves to DROP.
  - DST: 6 bytes compared to DST_ADDR; dst_addr_valid = 1 after the 6th byte only if all 6 matched; then SRC.
  - SRC: 6 bytes compared to SRC_ADDR; same rule for src_addr_valid; then TYPE.
  - TYPE: 2 bytes compared to TYPE_LEN; same rule for type_length_valid; then PAYLOAD.
  - PAYLOAD: consumes bytes until control = 0.
  - DROP: ignores bytes until control = 0.
- A field mismatch does not abort parsing. Later fields are still checked and flagged.
- Frame length counter:
  - Counts every control=1 byte from the first DST byte onward.
  - 11 bits, saturating at 2047.
- End of packet = first edge with control = 0 after preamble_valid was set.
  - packet_size_valid = 1 iff the parse reached PAYLOAD and MIN_FRAME ≤ length ≤ MAX_FRAME.
  - If preamble, dst, src, type and size checks all pass, valid_packet_counter increments by 1. It wraps 15 → 0.
  - State returns to PREAMBLE.
- control = 0 before PAYLOAD (truncated frame): packet_size_valid = 0, no increment.
- All five flags clear to 0 on the first control=1 byte after an IFG. Flags hold their values across the IFG so they are readable during the gap.
- control = 0 while in PREAMBLE (no SFD seen): the preamble count clears; no other effect.
- Multiple IFG cycles are equivalent to one.
- Bytes with control = 1 before a valid preamble (e.g. 0x00) are ignored.
- The counter is modified only at end of packet or by reset.

Optional Feature:
- Macro COUNTER_SATURATE_EN.
- When defined: valid_packet_counter saturates at 15; further valid packets leave it at 15.
- When undefined (default): the counter wraps 15 → 0.

Test Plan:
- Leading 0x00, then 7×0x55, 0xD5, DST 01..06, SRC FF..FA, 08 00, 49×0x55 + 1 FCS byte (64-byte frame), 1 IFG cycle -> all five flags = 1, counter = 1.
- Same frame but DST bytes 5–6 = FF FF, IFG of 3 cycles -> dst_addr_valid = 0, other flags = 1, counter unchanged at 1.
- Assert reset for 2 cycles during the IFG -> all flags = 0, counter = 0. Then a frame with SRC bytes 5–6 = 00 00 -> src_addr_valid = 0, counter = 0. Then a valid frame -> counter = 1.
- Valid header followed by only 30 payload bytes (44-byte frame) -> packet_size_valid = 0, counter unchanged. A frame of 1519 bytes -> packet_size_valid = 0.
- Only 5×0x55 before 0xD5 -> preamble_valid = 0, remaining flags = 0, counter unchanged. control dropped after 3 DST bytes -> no increment.
- 16 consecutive valid frames from counter = 0 -> counter = 0 (wrap), or 15 with COUNTER_SATURATE_EN defined.
